cell_pos_reader: RTL and testbench

Read-side controller for one cell position memory (single-port RAM, 2-cycle read latency, address 0 = particle count, addresses 1..N = {posz,posy,posx}). On a start pulse it fetches the count, then streams every particle record out over a valid/ready interface with a particle index and last flag. Sits between a cell memory instance and the position cache / force pipeline front end, and hides RAM latency and downstream backpressure.

---
 rtl/md_cell_pkg.sv | 18 +
 rtl/cell_pos_skid_fifo.sv | 64 ++++++
 rtl/cell_pos_reader.sv | 203 ++++++++++++++++++++
 tb/tb_cell_pos_reader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/md_cell_pkg.sv
// rtl/md_cell_pkg.sv - shared constants and FSM state type for cell memory readers
package md_cell_pkg;

    localparam int POS_WIDTH       = 32;
    localparam int CELL_DATA_WIDTH = 3 * POS_WIDTH;
    localparam int RAM_RD_LATENCY  = 2;
    localparam int COUNT_ADDR      = 0;

    typedef enum logic [2:0] {
        IDLE,
        REQ_CNT,
        WAIT_CNT,
        STREAM,
        DRAIN,
        FINISH
    } cell_rd_state_t;

endpackage

// File: rtl/cell_pos_skid_fifo.sv
// rtl/cell_pos_skid_fifo.sv - synchronous first-word-fall-through FIFO used as output skid buffer
module cell_pos_skid_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Storage needs no reset; only pointers and occupancy define FIFO state.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/cell_pos_reader.sv
// rtl/cell_pos_reader.sv - streams one cell's particle count and position records out of its RAM
module cell_pos_reader
    import md_cell_pkg::*;
#(
    parameter int DATA_WIDTH   = CELL_DATA_WIDTH,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] particle_count,
    output logic                  count_err,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_rden,
    output logic                  ram_wren,
    output logic [DATA_WIDTH-1:0] ram_data,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pos,
    output logic [ADDR_WIDTH-1:0] out_pid,
    output logic                  out_last
);

    localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);
    localparam int ENTRY_W = DATA_WIDTH + ADDR_WIDTH + 1;
    localparam int IF_W    = $clog2(RAM_RD_LATENCY + 1);
    localparam int FCNT_W  = $clog2(FIFO_DEPTH + 1);

    cell_rd_state_t state;
    cell_rd_state_t state_nxt;

    logic                  wait_cnt;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  last_accepted;
    logic                  issue;
    logic                  credit_ok;
    logic                  drain_ok;
    logic [ADDR_WIDTH-1:0] cnt_raw;
    logic [ADDR_WIDTH-1:0] cnt_clamped;

    logic                  pipe_valid [RAM_RD_LATENCY];
    logic [ADDR_WIDTH-1:0] pipe_addr  [RAM_RD_LATENCY];
    logic [IF_W-1:0]       in_flight;

    logic                  fifo_push;
    logic [ENTRY_W-1:0]    fifo_push_data;
    logic                  fifo_pop;
    logic [ENTRY_W-1:0]    fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FCNT_W-1:0]     fifo_count;

    assign ram_wren = 1'b0;
    assign ram_data = '0;
    assign busy     = (state != IDLE);

    assign cnt_raw     = ram_q[ADDR_WIDTH-1:0];
    assign cnt_clamped = (cnt_raw > MAX_COUNT) ? MAX_COUNT : cnt_raw;

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RAM_RD_LATENCY; i++) begin
            in_flight = in_flight + IF_W'(pipe_valid[i]);
        end
    end

    // Every issued read already owns a FIFO slot, so returns can never be dropped.
    assign credit_ok = !fifo_full && ((int'(in_flight) + int'(fifo_count)) < FIFO_DEPTH);

    assign out_valid = !fifo_empty;
    assign fifo_pop  = out_valid && out_ready;
    assign {out_pos, out_pid, out_last} = out_valid ? fifo_head : '0;

    // The final acceptance may happen this cycle, letting done follow it immediately.
    assign drain_ok = (in_flight == '0) &&
                      ((last_accepted && fifo_empty) || (fifo_pop && out_last));

    always_comb begin
        state_nxt = state;
        ram_rden  = 1'b0;
        ram_addr  = '0;
        issue     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = REQ_CNT;
                end
            end
            REQ_CNT: begin
                ram_rden  = 1'b1;
                ram_addr  = ADDR_WIDTH'(COUNT_ADDR);
                state_nxt = WAIT_CNT;
            end
            WAIT_CNT: begin
                if (wait_cnt) begin
                    state_nxt = (cnt_clamped == '0) ? FINISH : STREAM;
                end
            end
            STREAM: begin
                if (credit_ok) begin
                    issue    = 1'b1;
                    ram_rden = 1'b1;
                    ram_addr = next_addr;
                    if (next_addr == particle_count) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_ok) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            wait_cnt       <= 1'b0;
            next_addr      <= '0;
            particle_count <= '0;
            count_err      <= 1'b0;
            last_accepted  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        wait_cnt      <= 1'b0;
                        count_err     <= 1'b0;
                        last_accepted <= 1'b0;
                    end
                end
                WAIT_CNT: begin
                    wait_cnt <= 1'b1;
                    if (wait_cnt) begin
                        particle_count <= cnt_clamped;
                        count_err      <= (cnt_raw > MAX_COUNT);
                        next_addr      <= ADDR_WIDTH'(1);
                    end
                end
                STREAM: begin
                    if (issue) begin
                        next_addr <= next_addr + 1'b1;
                    end
                end
                default: ;
            endcase
            if (fifo_pop && out_last) begin
                last_accepted <= 1'b1;
            end
        end
    end

    // Address/valid shadow of the RAM read pipeline, aligned with ram_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RAM_RD_LATENCY; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_addr[i]  <= '0;
            end
        end else begin
            pipe_valid[0] <= issue;
            pipe_addr[0]  <= ram_addr;
            for (int i = 1; i < RAM_RD_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_addr[i]  <= pipe_addr[i-1];
            end
        end
    end

    assign fifo_push      = pipe_valid[RAM_RD_LATENCY-1];
    assign fifo_push_data = {ram_q, pipe_addr[RAM_RD_LATENCY-1],
                             (pipe_addr[RAM_RD_LATENCY-1] == particle_count)};

    cell_pos_skid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_skid_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_cell_pos_reader.sv
// tb/tb_cell_pos_reader.sv - scoreboard bench for cell_pos_reader
module tb_cell_pos_reader;

    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;
    localparam int RW = DW + AW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic [AW-1:0] particle_count;
    logic          count_err;
    logic [AW-1:0] ram_addr;
    logic          ram_rden;
    logic          ram_wren;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] ram_q = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_pos;
    logic [AW-1:0] out_pid;
    logic          out_last;

    cell_pos_reader #(
        .DATA_WIDTH   (DW),
        .PARTICLE_NUM (PN),
        .ADDR_WIDTH   (AW),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .particle_count (particle_count),
        .count_err      (count_err),
        .ram_addr       (ram_addr),
        .ram_rden       (ram_rden),
        .ram_wren       (ram_wren),
        .ram_data       (ram_data),
        .ram_q          (ram_q),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pos        (out_pos),
        .out_pid        (out_pid),
        .out_last       (out_last)
    );

    always #5 clk = ~clk;

    // Two-cycle-latency RAM model
    logic [DW-1:0] mem [PN];
    logic [DW-1:0] rd1 = '0;
    always @(posedge clk) begin
        if (ram_rden) rd1 <= mem[ram_addr];
        ram_q <= rd1;
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [RW-1:0] exp_q [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pos_of(input int i);
        return {32'h3000_0000 | 32'(i), 32'h2000_0000 | 32'(i), 32'h1000_0000 | 32'(i)};
    endfunction

    task automatic load(input int cnt_word, input int n_exp);
        mem[0] = {32'hDEAD_BEEF, 56'h0, 8'(cnt_word)};
        for (int i = 1; i < PN; i++) mem[i] = pos_of(i);
        exp_q.delete();
        for (int i = 1; i <= n_exp; i++) exp_q.push_back({pos_of(i), 8'(i), (i == n_exp)});
    endtask

    // Monitor: scoreboard pop, stall stability, read credit and address bounds
    int            issued = 0;
    int            accepted = 0;
    int            max_addr = 0;
    logic          prev_stall = 1'b0;
    logic [RW-1:0] prev_rec = '0;
    always @(negedge clk) begin
        if (rst) begin
            issued     = 0;
            accepted   = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", 128'({out_valid, out_pos, out_pid, out_last}), 128'({1'b1, prev_rec}));
            if (ram_rden && ram_addr != 0) begin
                check("read_credit", 128'((issued - accepted) < 4), 128'(1));
                check("addr_bound", 128'(ram_addr <= particle_count && ram_addr <= PN - 1), 128'(1));
                if (int'(ram_addr) > max_addr) max_addr = int'(ram_addr);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_record: got pid %0d expected none", out_pid);
                end else begin
                    check("record", 128'({out_pos, out_pid, out_last}), 128'(exp_q.pop_front()));
                end
            end
            if (ram_rden && ram_addr != 0) issued++;
            if (out_valid && out_ready) accepted++;
            prev_stall = out_valid && !out_ready;
            prev_rec   = {out_pos, out_pid, out_last};
        end
    end

    function automatic logic rdy(input int mode, input int k);
        if (mode == 1) return ((k - 1) % 4 == 0) || ((k - 1) % 4 == 3);
        return 1'b1;
    endfunction

    // Called at posedge+1; k counts cycles after the one in which start is sampled.
    task automatic run_xfer(input int mode, input int budget, input int abort_after,
                            output int k_rden, output int k_valid, output int k_last,
                            output int k_done, output int n_done);
        int acc = 0;
        k_rden = 0; k_valid = 0; k_last = 0; k_done = 0; n_done = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        out_ready = rdy(mode, 1);
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (ram_rden && ram_addr != 0 && k_rden == 0) k_rden = k;
            if (out_valid && k_valid == 0) k_valid = k;
            if (out_valid && out_ready) begin
                acc++;
                if (out_last) k_last = k;
            end
            if (done) begin
                n_done++;
                if (k_done == 0) k_done = k;
            end
            if (abort_after > 0 && acc == abort_after) break;
            if (k_done != 0 && k > k_done + 3) break;
            @(posedge clk); #1;
            out_ready = rdy(mode, k + 1);
            start = (mode == 3) && (k + 1 == 2 || k + 1 == 5 || k + 1 == 10);
        end
        start = 1'b0;
        if (abort_after == 0) check("xfer_done_seen", 128'(k_done != 0), 128'(1));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ctl"}, 128'({busy, done, count_err, ram_rden, ram_wren, out_valid, out_last}), 128'(0));
        check({tag, "_addr_pid"}, 128'({ram_addr, out_pid, particle_count}), 128'(0));
        check({tag, "_data"}, 128'({ram_data, out_pos}), 128'(0));
    endtask

    int kr, kv, kl, kd, nd;

    initial begin
        for (int i = 0; i < PN; i++) mem[i] = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: five records, full throughput
        load(5, 5);
        run_xfer(0, 100, 0, kr, kv, kl, kd, nd);
        check("t1_first_read_cycle", 128'(kr), 128'(4));
        check("t1_read_to_valid", 128'(kv - kr), 128'(3));
        check("t1_back_to_back", 128'(kl - kv), 128'(4));
        check("t1_done_after_last", 128'(kd - kl), 128'(1));
        check("t1_done_pulses", 128'(nd), 128'(1));
        check("t1_count", 128'({particle_count, count_err}), 128'({8'd5, 1'b0}));
        check("t1_all_received", 128'(exp_q.size()), 128'(0));
        @(posedge clk); #1;

        // 2: empty cell
        load(0, 0);
        run_xfer(0, 100, 0, kr, kv, kl, kd, nd);
        check("t2_done_cycle", 128'(kd), 128'(4));
        check("t2_no_valid", 128'(kv), 128'(0));
        check("t2_count", 128'({particle_count, count_err}), 128'(0));
        @(posedge clk); #1;

        // 3: ten records under 1,0,0,1 backpressure
        load(10, 10);
        run_xfer(1, 300, 0, kr, kv, kl, kd, nd);
        check("t3_done_pulses", 128'(nd), 128'(1));
        check("t3_all_received", 128'(exp_q.size()), 128'(0));
        check("t3_count", 128'({particle_count, count_err}), 128'({8'd10, 1'b0}));
        out_ready = 1'b1;
        @(posedge clk); #1;

        // 4: oversized count word is clamped
        load(250, PN - 1);
        max_addr = 0;
        run_xfer(0, 1000, 0, kr, kv, kl, kd, nd);
        check("t4_count", 128'({particle_count, count_err}), 128'({8'd219, 1'b1}));
        check("t4_max_addr", 128'(max_addr), 128'(219));
        check("t4_all_received", 128'(exp_q.size()), 128'(0));
        @(posedge clk); #1;

        // 5: reset after three accepted records, then restart
        load(8, 8);
        run_xfer(0, 100, 3, kr, kv, kl, kd, nd);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("t5_reset");
        exp_q.delete();
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("t5_quiet", 128'({out_valid, ram_rden, busy}), 128'(0));
        end
        @(posedge clk); #1;
        load(8, 8);
        run_xfer(0, 100, 0, kr, kv, kl, kd, nd);
        check("t5_done_pulses", 128'(nd), 128'(1));
        check("t5_all_received", 128'(exp_q.size()), 128'(0));
        @(posedge clk); #1;

        // 6: start re-pulsed while busy and in the done cycle
        load(3, 3);
        run_xfer(3, 100, 0, kr, kv, kl, kd, nd);
        check("t6_done_cycle", 128'(kd), 128'(10));
        check("t6_done_pulses", 128'(nd), 128'(1));
        check("t6_idle_after", 128'(busy), 128'(0));
        check("t6_all_received", 128'(exp_q.size()), 128'(0));

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
